// File: rtl/rr_mux_arbiter_if.sv
// Request/data/grant channel between NUM_INPUTS producers, the arbiter and one consumer.
// The arbiter attaches through the slave modport; the producers and the consumer attach through master.
interface rr_mux_arbiter_if #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned WIDTH      = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]       req;
  logic [NUM_INPUTS*WIDTH-1:0] w;
  logic [NUM_INPUTS-1:0]       ack;
  logic [WIDTH-1:0]            out;
  logic [SEL_W-1:0]            out_sel;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output req, w, out_ready, input ack, out, out_sel, out_valid);
  modport slave  (input req, w, out_ready, output ack, out, out_sel, out_valid);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that muxes one of NUM_INPUTS words into a registered valid/ready output stage.
// ack is a combinational one-hot strobe that marks the cycle in which the winner's word is captured.
module rr_mux_arbiter #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned WIDTH      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_if.slave    bus
);
  localparam int unsigned SEL_W = $clog2(NUM_INPUTS);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic             load_en;
  logic             capture;
  logic [WIDTH-1:0] win_word;

  assign load_en = !bus.out_valid || bus.out_ready;
  assign capture = load_en && any_req;

  // Circular search ptr, ptr+1, ..., wrapping at NUM_INPUTS; the first hit wins.
  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    winner  = ptr;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NUM_INPUTS)) begin
        sum = sum - (SEL_W+1)'(NUM_INPUTS);
      end
      idx = SEL_W'(sum);
      if (!any_req && bus.req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // Data mux; the winner index never exceeds NUM_INPUTS-1, so out never goes X.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (winner == SEL_W'(i)) begin
        win_word = bus.w[i*int'(WIDTH) +: WIDTH];
      end
    end
  end

  // One-hot grant strobe, held low while reset is asserted.
  always_comb begin
    bus.ack = '0;
    if (rst_n && capture) begin
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        bus.ack[i] = (winner == SEL_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_sel   <= '0;
      bus.out_valid <= 1'b0;
      ptr           <= '0;
    end else if (capture) begin
      bus.out       <= win_word;
      bus.out_sel   <= winner;
      bus.out_valid <= 1'b1;
      ptr           <= (winner == SEL_W'(NUM_INPUTS - 1)) ? '0 : winner + SEL_W'(1);
    end else if (load_en) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit output channel among NUM_INPUTS requesters.
- Each requester presents a request and a data word on a flattened input bus, packed like the general mux: word i occupies bits i*WIDTH +: WIDTH.
- The block selects a winner, captures the winner's word into a registered output stage and presents it with valid/ready flow control.
- Sits between several producers and a single downstream consumer; the output register decouples producer timing from consumer timing.

Parameters:
- NUM_INPUTS, 5, number of requesters; legal range 2..64.
- WIDTH, 4, data width per requester.
- SEL_W (localparam), $clog2(NUM_INPUTS), width of the index outputs.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_INPUTS  req[i]=1: requester i has a word on w[i*WIDTH +: WIDTH].
- w  input  NUM_INPUTS*WIDTH  flattened data words, word i at bits i*WIDTH +: WIDTH.
- ack  output  NUM_INPUTS  one-hot combinational strobe; ack[i]=1 in the cycle word i is captured.
- out  output  WIDTH  registered data of the current grant.
- out_sel  output  SEL_W  registered index of the requester whose word is in out.
- out_valid  output  1  out/out_sel hold a word not yet taken.
- out_ready  input  1  consumer accepts out when out_valid && out_ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out=0, out_sel=0, out_valid=0, priority pointer ptr=0.
  - ack forced to 0 while rst_n is low, regardless of req.
- Slot free: load_en = !out_valid || out_ready. Combinational.
- Winner selection: the first i with req[i]=1, searched circularly from ptr: ptr, ptr+1, ..., NUM_INPUTS-1, 0, ..., ptr-1.
- When load_en and any req is set (capture cycle):
  - ack[winner]=1; all other ack bits 0.
  - At the clock edge: out <= w[winner*WIDTH +: WIDTH], out_sel <= winner, out_valid <= 1.
  - ptr <= winner+1, wrapping to 0 when winner = NUM_INPUTS-1.
- When load_en and no req is set:
  - ack=0.
  - At the clock edge: out_valid <= 0.
  - out, out_sel and ptr hold their values.
- When out_valid && !out_ready (stall):
  - ack=0.
  - out, out_sel, out_valid and ptr all hold.
- Simultaneous drain and capture: when out_valid && out_ready && req is nonzero, the old word is consumed and the new word is loaded in the same cycle. Full throughput is one word per cycle.
- Latency: the word is captured in the ack cycle and appears on out with out_valid=1 in the next cycle.
- Requester rule:
  - Requester i holds req[i] and its word stable until it sees ack[i].
  - A requester may drop req[i] before ack[i] (withdraw). The arbiter never acks a deasserted request.
- Fairness: with req[i] held, requester i is acked within NUM_INPUTS load_en cycles.
- ack is a combinational function of req, ptr, out_valid, out_ready and rst_n. It has no combinational path from w.
- Data out of range: none possible. The winner index is always < NUM_INPUTS, so no X is produced on out.
- Reset asserted mid-stall: a held word is discarded; out_valid drops immediately (asynchronously).
- After reset release, the first capture starts its search from index 0.

Test Plan:
1. Reset/idle:
   - Stimulus: rst_n=0 with req=5'b11111, then release with req=0 for 3 cycles.
   - Required: ack=0 throughout; out_valid=0; out=0; out_sel=0.
2. Single requester:
   - Stimulus: req=5'b00100, w word2=4'hA, out_ready=1.
   - Required: ack=5'b00100 in cycle 0; next cycle out=4'hA, out_sel=2, out_valid=1.
3. Round-robin rotation:
   - Stimulus: req=5'b11111 held, out_ready=1, words i = 4'h1..4'h5.
   - Required: out_sel sequence 0,1,2,3,4,0; out values 1,2,3,4,5,1; one word per cycle.
4. Backpressure:
   - Stimulus: req=5'b00011, out_ready=0 for 4 cycles after the first capture.
   - Required: out=word0 and out_valid=1 held for 4 cycles; ack=0 during the stall.
   - Then with out_ready=1: ack=5'b00010 in the same cycle; out_sel=1 on the next cycle.
5. Wrap and skip:
   - Stimulus: after the last grant to requester 3 (ptr=4), req=5'b01001.
   - Required: first ack goes to requester 0 (4 is idle, wrap), then requester 3; requester 0 is not acked twice in a row.
6. Reset mid-operation:
   - Stimulus: assert rst_n low while out_valid=1 and out_ready=0.
   - Required: out_valid=0 before the next clk edge; after release, req=5'b10001 acks requester 0 first.
